// File: rtl/stream_sort_norm_pkg.sv
// -----------------------------------------------------------------------------
// stream_sort_norm_pkg
// Shared types and helpers for the streaming sorter/normaliser.
//   - state_e      : frame controller states
//   - MODE_*       : bit positions inside the 3-bit frame mode word
//   - goes_before  : signed/unsigned, direction-aware strict ordering test
// -----------------------------------------------------------------------------
package stream_sort_norm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CALC = 2'd2,
      ST_OUT  = 2'd3
   } state_e;

   localparam int MODE_NORM   = 0;
   localparam int MODE_ASC    = 1;
   localparam int MODE_SIGNED = 2;

   // Operands arrive already sign- or zero-extended to CMP_W bits by the
   // caller, which keeps this helper independent of the element width.
   localparam int CMP_W = 32;

   // True when element a must be placed strictly before element b. Strictness
   // is what makes a newly inserted element land after existing equal ones.
   function automatic logic goes_before(input logic [CMP_W-1:0] a,
                                        input logic [CMP_W-1:0] b,
                                        input logic             is_signed,
                                        input logic             asc);
      logic lt;
      logic gt;
      lt = is_signed ? ($signed(a) < $signed(b)) : (a < b);
      gt = is_signed ? ($signed(a) > $signed(b)) : (a > b);
      return asc ? lt : gt;
   endfunction

endpackage

// File: rtl/sort_insert_cell.sv
// -----------------------------------------------------------------------------
// sort_insert_cell
// One slot of the insertion-sort array: holds an element, compares the
// incoming element against it and selects keep / take-new / shift-from-left.
// Ports:
//   clk, rst         : clock, synchronous active-high reset (clears the slot)
//   load_en_i        : an element is being inserted this cycle
//   occupied_i       : this slot already holds a valid element of the frame
//   prev_before_i    : new element goes at or before the slot on the left
//   new_data_i       : element being inserted
//   prev_data_i      : contents of the slot on the left
//   is_signed_i      : compare as two's complement
//   asc_i            : ascending order when 1, descending when 0
//   slot_o           : current slot contents
//   before_o         : new element goes at or before this slot
// -----------------------------------------------------------------------------
module sort_insert_cell
   import stream_sort_norm_pkg::*;
#(
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en_i,
   input  logic              occupied_i,
   input  logic              prev_before_i,
   input  logic [DATA_W-1:0] new_data_i,
   input  logic [DATA_W-1:0] prev_data_i,
   input  logic              is_signed_i,
   input  logic              asc_i,
   output logic [DATA_W-1:0] slot_o,
   output logic              before_o
);

   logic [DATA_W-1:0] slot_q;
   logic [DATA_W-1:0] slot_d;
   logic [CMP_W-1:0]  new_ext;
   logic [CMP_W-1:0]  slot_ext;

   assign new_ext  = is_signed_i ? CMP_W'($signed(new_data_i)) : CMP_W'(new_data_i);
   assign slot_ext = is_signed_i ? CMP_W'($signed(slot_q))     : CMP_W'(slot_q);

   // An empty slot always accepts, so the flag chain stays monotonic: once a
   // slot reports 1, every slot to its right does too.
   assign before_o = occupied_i ? goes_before(new_ext, slot_ext, is_signed_i, asc_i) : 1'b1;

   always_comb begin
      // NOTE: default first so every path assigns slot_d and no latch is inferred.
      slot_d = slot_q;
      if (load_en_i) begin
         if (prev_before_i) begin
            slot_d = prev_data_i;   // insertion point is to the left: shift right
         end else if (before_o) begin
            slot_d = new_data_i;    // this is the insertion point
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: the slot is a register, not a RAM, so it can and does reset to 0;
      // non-blocking assignment keeps all slots updating from pre-edge values.
      if (rst) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign slot_o = slot_q;

endmodule

// File: rtl/stream_sort_norm.sv
// -----------------------------------------------------------------------------
// stream_sort_norm
// Accepts a frame of NUM elements over a valid/ready stream, insertion-sorts
// them as they arrive, optionally subtracts the mid-range offset (min+max)/2
// and streams the result out with back-pressure.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : input handshake
//   in_data [DATA_W]      : input element
//   in_mode [3]           : [0] normalise, [1] ascending, [2] signed;
//                           sampled on the first beat of a frame only
//   out_valid/out_ready   : output handshake
//   out_data [DATA_W+1]   : sorted, optionally normalised element
//   out_last              : final element of the frame
//   busy                  : controller is not idle
// -----------------------------------------------------------------------------
module stream_sort_norm
   import stream_sort_norm_pkg::*;
#(
   parameter  int DATA_W = 4,
   parameter  int NUM    = 5,
   localparam int OUT_W  = DATA_W + 1,
   localparam int CNT_W  = $clog2(NUM + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [2:0]        in_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_last,
   output logic              busy
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   k_q, k_d;
   logic [2:0]         mode_q, mode_d;
   logic [OUT_W-1:0]   offset_q, offset_d;
   logic [OUT_W-1:0]   out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d;
   logic               out_last_q, out_last_d;

   logic               in_accept;
   logic               out_accept;
   logic               sgn;
   logic [DATA_W-1:0]  slot_w   [NUM];
   logic               before_w [NUM];
   logic [CNT_W-1:0]   k_nxt;
   logic [DATA_W-1:0]  next_elem;
   logic [OUT_W-1:0]   sum;
   logic [OUT_W-1:0]   half;

   function automatic logic [OUT_W-1:0] ext(input logic [DATA_W-1:0] v, input logic s);
      return s ? {v[DATA_W-1], v} : {1'b0, v};
   endfunction

   assign in_ready   = (state_q == ST_IDLE) || (state_q == ST_LOAD);
   assign busy       = (state_q != ST_IDLE);
   assign in_accept  = in_valid && in_ready;
   assign out_accept = out_valid_q && out_ready;
   assign sgn        = mode_q[MODE_SIGNED];

   // ---------------------------------------------------------------- sort array
   for (genvar i = 0; i < NUM; i++) begin : g_cell
      logic              prev_before;
      logic [DATA_W-1:0] prev_data;
      if (i == 0) begin : g_head
         assign prev_before = 1'b0;
         assign prev_data   = '0;
      end else begin : g_body
         assign prev_before = before_w[i-1];
         assign prev_data   = slot_w[i-1];
      end

      sort_insert_cell #(.DATA_W(DATA_W)) u_cell (
         .clk           (clk),
         .rst           (rst),
         .load_en_i     (in_accept),
         .occupied_i    (cnt_q > CNT_W'(i)),
         .prev_before_i (prev_before),
         .new_data_i    (in_data),
         .prev_data_i   (prev_data),
         .is_signed_i   (sgn),
         .asc_i         (mode_q[MODE_ASC]),
         .slot_o        (slot_w[i]),
         .before_o      (before_w[i])
      );
   end

   // ------------------------------------------------------- normalise datapath
   // The sum of the two extremes fits in OUT_W bits for both signednesses.
   // Signed halving rounds toward zero: arithmetic shift floors, so negative
   // odd sums get +1 back.
   always_comb begin
      sum  = ext(slot_w[0], sgn) + ext(slot_w[NUM-1], sgn);
      half = {1'b0, sum[OUT_W-1:1]};
      if (sgn) begin
         half = {sum[OUT_W-1], sum[OUT_W-1:1]}
              + {{(OUT_W-1){1'b0}}, sum[OUT_W-1] & sum[0]};
      end
   end

   assign k_nxt = k_q + 1'b1;

   always_comb begin
      next_elem = slot_w[0];
      for (int i = 0; i < NUM; i++) begin
         if (k_nxt == CNT_W'(i)) begin
            next_elem = slot_w[i];
         end
      end
   end

   // ------------------------------------------------------------- controller
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      k_d         = k_q;
      mode_d      = mode_q;
      offset_d    = offset_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;

      unique case (state_q)
         ST_IDLE: begin
            if (in_accept) begin
               mode_d  = in_mode;
               cnt_d   = CNT_W'(1);
               state_d = (NUM == 1) ? ST_CALC : ST_LOAD;
            end
         end

         ST_LOAD: begin
            if (in_accept) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(NUM - 1)) begin
                  state_d = ST_CALC;
               end
            end
         end

         ST_CALC: begin
            offset_d    = mode_q[MODE_NORM] ? half : '0;
            out_data_d  = ext(slot_w[0], sgn) - offset_d;
            out_valid_d = 1'b1;
            out_last_d  = (NUM == 1);
            k_d         = '0;
            state_d     = ST_OUT;
         end

         ST_OUT: begin
            if (out_accept) begin
               if (out_last_q) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  cnt_d       = '0;
                  k_d         = '0;
                  state_d     = ST_IDLE;
               end else begin
                  k_d        = k_nxt;
                  out_data_d = ext(next_elem, sgn) - offset_q;
                  out_last_d = (k_nxt == CNT_W'(NUM - 1));
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         k_q         <= '0;
         mode_q      <= '0;
         offset_q    <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         k_q         <= k_d;
         mode_q      <= mode_d;
         offset_q    <= offset_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;

endmodule
